// File: rtl/ptp_ts_queue_if.sv
// Parser/stream inputs and host-side queue access for the PTP timestamp queue.
// The master drives stream, parser and host strobes; the queue is the slave.
interface ptp_ts_queue_if #(
  parameter int DEPTH_LOG2 = 4,
  parameter int TS_W       = 64
);
  logic [TS_W-1:0]    rtc_time;
  logic               int_valid;
  logic               int_sop;
  logic               ptp_found;
  logic [31:0]        ptp_infor;
  logic               cfg_en;
  logic               q_clear;
  logic               q_rd;
  logic [TS_W+31:0]   q_rd_data;
  logic               q_empty;
  logic               q_full;
  logic [DEPTH_LOG2:0] q_count;
  logic [7:0]         q_ovf_cnt;

  modport master (
    output rtc_time, int_valid, int_sop, ptp_found, ptp_infor, cfg_en, q_clear, q_rd,
    input  q_rd_data, q_empty, q_full, q_count, q_ovf_cnt
  );

  modport slave (
    input  rtc_time, int_valid, int_sop, ptp_found, ptp_infor, cfg_en, q_clear, q_rd,
    output q_rd_data, q_empty, q_full, q_count, q_ovf_cnt
  );
endinterface

// File: rtl/ptp_ts_queue.sv
// Captures RTC time at each start-of-packet and queues {timestamp, infor} when
// the parser flags a PTP event; the host drains the queue first-word-fall-through.
module ptp_ts_queue #(
  parameter int DEPTH_LOG2 = 4,
  parameter int TS_W       = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  ptp_ts_queue_if.slave bus
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int E_W   = TS_W + 32;
  localparam logic [DEPTH_LOG2:0]   DEPTH_C = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0]   CNT_ONE = {{DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

  logic [E_W-1:0]        r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_count;
  logic [7:0]            r_ovf_cnt;
  logic [TS_W-1:0]       r_ts_pend;
  logic                  r_found_d1;

  logic w_empty;
  logic w_full;
  logic w_push_req;
  logic w_pop;
  logic w_push_ok;
  logic w_drop;

  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == DEPTH_C);
  assign w_push_req = bus.ptp_found & ~r_found_d1 & bus.cfg_en;
  assign w_pop      = bus.q_rd & ~w_empty;
  // A pop on the same edge frees the slot, so a full queue still accepts the push.
  assign w_push_ok  = w_push_req & (~w_full | w_pop);
  assign w_drop     = w_push_req & w_full & ~w_pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_ovf_cnt  <= '0;
      r_ts_pend  <= '0;
      r_found_d1 <= 1'b0;
    end else begin
      r_found_d1 <= bus.ptp_found;
      if (bus.int_valid && bus.int_sop)
        r_ts_pend <= bus.rtc_time;
      if (bus.q_clear) begin
        r_wr_ptr  <= '0;
        r_rd_ptr  <= '0;
        r_count   <= '0;
        r_ovf_cnt <= '0;
      end else begin
        if (w_push_ok)
          r_wr_ptr <= r_wr_ptr + PTR_ONE;
        if (w_pop)
          r_rd_ptr <= r_rd_ptr + PTR_ONE;
        if (w_push_ok && !w_pop)
          r_count <= r_count + CNT_ONE;
        else if (!w_push_ok && w_pop)
          r_count <= r_count - CNT_ONE;
        if (w_drop && (r_ovf_cnt != 8'hFF))
          r_ovf_cnt <= r_ovf_cnt + 8'd1;
      end
    end
  end

  // Storage needs no reset: an empty queue masks the head to zero.
  always_ff @(posedge clk) begin
    if (w_push_ok && !bus.q_clear)
      r_mem[r_wr_ptr] <= {r_ts_pend, bus.ptp_infor};
  end

  assign bus.q_rd_data = w_empty ? '0 : r_mem[r_rd_ptr];
  assign bus.q_empty   = w_empty;
  assign bus.q_full    = w_full;
  assign bus.q_count   = r_count;
  assign bus.q_ovf_cnt = r_ovf_cnt;
endmodule

// File: tb/tb_ptp_ts_queue.sv
// Directed/randomized bench for ptp_ts_queue; a queue-based reference model
// predicts every output after each clock edge.
module tb_ptp_ts_queue;
  localparam int DL   = 4;
  localparam int TSW  = 64;
  localparam int DEPTH = 1 << DL;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_fail = 0;

  ptp_ts_queue_if #(.DEPTH_LOG2(DL), .TS_W(TSW)) bus ();
  ptp_ts_queue #(.DEPTH_LOG2(DL), .TS_W(TSW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  // reference model state
  logic [95:0] mq [$];
  logic [63:0] m_ts_pend;
  logic        m_found_prev;
  int          m_ovf;

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_ts_pend    = '0;
    m_found_prev = 1'b0;
    m_ovf        = 0;
  endtask

  task automatic model_step();
    logic push;
    push = bus.ptp_found && !m_found_prev && bus.cfg_en;
    if (bus.q_clear) begin
      mq.delete();
      m_ovf = 0;
    end else begin
      if (bus.q_rd && mq.size() > 0) void'(mq.pop_front());
      if (push) begin
        if (mq.size() < DEPTH) mq.push_back({m_ts_pend, bus.ptp_infor});
        else if (m_ovf < 255) m_ovf++;
      end
    end
    m_found_prev = bus.ptp_found;
    if (bus.int_valid && bus.int_sop) m_ts_pend = bus.rtc_time;
  endtask

  task automatic check_all(input string tag);
    logic [95:0] head;
    head = (mq.size() > 0) ? mq[0] : '0;
    chk({tag, ".empty"}, 96'(bus.q_empty), 96'(mq.size() == 0));
    chk({tag, ".full"},  96'(bus.q_full),  96'(mq.size() == DEPTH));
    chk({tag, ".count"}, 96'(bus.q_count), 96'(mq.size()));
    chk({tag, ".ovf"},   96'(bus.q_ovf_cnt), 96'(m_ovf));
    chk({tag, ".data"},  bus.q_rd_data, head);
  endtask

  task automatic cycle(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic pkt(input logic [63:0] ts, input logic [31:0] inf, input bit rd, input bit clr);
    bus.int_valid = 1'b1;
    bus.int_sop   = 1'b1;
    bus.rtc_time  = ts;
    bus.ptp_found = 1'b0;
    bus.q_rd      = 1'b0;
    cycle("sop");
    bus.int_sop   = 1'b0;
    bus.rtc_time  = {$urandom, $urandom};
    bus.ptp_found = 1'b1;
    bus.ptp_infor = inf;
    bus.q_rd      = rd;
    bus.q_clear   = clr;
    cycle("found");
    bus.q_rd    = 1'b0;
    bus.q_clear = 1'b0;
  endtask

  task automatic pop_one(input string tag);
    bus.q_rd = 1'b1;
    cycle(tag);
    bus.q_rd = 1'b0;
  endtask

  function automatic logic [31:0] rinf(input int seq);
    logic [31:0] r;
    r = $urandom;
    return {r[31:16], 16'(seq)};
  endfunction

  initial begin
    logic [31:0] new_inf;
    bus.rtc_time = '0; bus.int_valid = 0; bus.int_sop = 0; bus.ptp_found = 0;
    bus.ptp_infor = '0; bus.cfg_en = 1; bus.q_clear = 0; bus.q_rd = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    @(negedge clk) rst_n = 1'b1;

    // single event with fixed values
    pkt(64'h0000_0005_0000_1000, 32'h1ABC_0007, 0, 0);
    chk("single.data", bus.q_rd_data, 96'h0000_0005_0000_1000_1ABC_0007);
    chk("single.count", 96'(bus.q_count), 96'd1);
    pop_one("single.pop");
    chk("single.empty", 96'(bus.q_empty), 96'd1);

    // q_rd on empty queue is harmless
    pop_one("rd_empty");

    // fill and overflow
    for (int i = 0; i < 18; i++) pkt({$urandom, $urandom}, rinf(i), 0, 0);
    chk("fill.full", 96'(bus.q_full), 96'd1);
    chk("fill.count", 96'(bus.q_count), 96'd16);
    chk("fill.ovf", 96'(bus.q_ovf_cnt), 96'd2);
    for (int i = 0; i < 16; i++) begin
      chk("fill.seq", 96'(bus.q_rd_data[15:0]), 96'(i));
      pop_one("fill.pop");
    end

    // wrap: push 10 / pop 10 twice, then push 5
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 10; i++) pkt({$urandom, $urandom}, rinf(i), 0, 0);
      for (int i = 0; i < 10; i++) pop_one("wrap.pop");
    end
    for (int i = 0; i < 5; i++) pkt({$urandom, $urandom}, rinf(100 + i), 0, 0);
    chk("wrap.count", 96'(bus.q_count), 96'd5);
    for (int i = 0; i < 5; i++) begin
      chk("wrap.seq", 96'(bus.q_rd_data[15:0]), 96'(100 + i));
      pop_one("wrap.pop5");
    end

    // full queue: push rise coincident with pop
    for (int i = 0; i < 16; i++) pkt({$urandom, $urandom}, rinf(i), 0, 0);
    new_inf = 32'hCAFE_0777;
    pkt({$urandom, $urandom}, new_inf, 1, 0);
    chk("simfull.count", 96'(bus.q_count), 96'd16);
    chk("simfull.ovf", 96'(bus.q_ovf_cnt), 96'd2);
    for (int i = 0; i < 15; i++) pop_one("simfull.pop");
    chk("simfull.last", 96'(bus.q_rd_data[31:0]), 96'(new_inf));
    pop_one("simfull.drain");

    // empty queue: push rise coincident with pop
    pkt({$urandom, $urandom}, rinf(55), 1, 0);
    chk("simempty.count", 96'(bus.q_count), 96'd1);
    pop_one("simempty.drain");

    // held level gives one push
    pkt({$urandom, $urandom}, rinf(60), 0, 0);
    repeat (20) cycle("held");
    chk("held.count", 96'(bus.q_count), 96'd1);

    // rise while disabled is lost for good
    bus.cfg_en = 1'b0;
    pkt({$urandom, $urandom}, rinf(61), 0, 0);
    cycle("dis");
    bus.cfg_en = 1'b1;
    repeat (3) cycle("reen");
    chk("cfgen.count", 96'(bus.q_count), 96'd1);
    pop_one("cfgen.drain");

    // clear with 7 entries and a coincident push
    for (int i = 0; i < 7; i++) pkt({$urandom, $urandom}, rinf(i), 0, 0);
    pkt({$urandom, $urandom}, rinf(7), 0, 1);
    chk("clear.count", 96'(bus.q_count), 96'd0);
    chk("clear.empty", 96'(bus.q_empty), 96'd1);
    chk("clear.ovf", 96'(bus.q_ovf_cnt), 96'd0);

    // random traffic
    for (int i = 0; i < 300; i++) begin
      bus.int_valid = $urandom_range(0, 1);
      bus.int_sop   = $urandom_range(0, 3) == 0;
      bus.rtc_time  = {$urandom, $urandom};
      if (bus.int_valid && bus.int_sop) bus.ptp_found = 1'b0;
      else if ($urandom_range(0, 2) == 0) bus.ptp_found = 1'b1;
      bus.ptp_infor = $urandom;
      bus.cfg_en    = $urandom_range(0, 7) != 0;
      bus.q_rd      = $urandom_range(0, 3) == 0;
      bus.q_clear   = $urandom_range(0, 63) == 0;
      cycle("rand");
    end
    bus.q_clear = 0; bus.q_rd = 0; bus.int_valid = 0; bus.int_sop = 0; bus.cfg_en = 1;

    // async reset mid-burst
    for (int i = 0; i < 5; i++) pkt({$urandom, $urandom}, rinf(i), 0, 0);
    bus.ptp_found = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    chk("async_rst.count", 96'(bus.q_count), 96'd0);
    @(negedge clk) rst_n = 1'b1;
    pkt(64'h0000_0009_0000_0002, 32'h2000_0001, 0, 0);
    chk("post_rst.data", bus.q_rd_data, 96'h0000_0009_0000_0002_2000_0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/ptp_ts_queue.md
Name: ptp_ts_queue

Overview:
- Timestamp queue controller sitting behind the PTP packet parser in the TSU.
- Captures the RTC time at each packet's start-of-packet and waits for the parser's ptp_found/ptp_infor verdict. When a PTP event is reported, it pushes {timestamp, infor} into a circular buffer.
- The host drains the buffer through a pop handshake. The block tracks fill level and dropped entries.

Parameters:
- DEPTH_LOG2, 4, log2 of queue depth (default 16 entries); legal range 2..6.
- TS_W, 64, RTC timestamp width ({seconds[31:0], nanoseconds[31:0]} by default).

Ports:
- clk  input  1  single system clock; all state on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- rtc_time  input  TS_W  free-running RTC time, synchronous to clk.
- int_valid  input  1  stream word valid (same stream as the parser input).
- int_sop  input  1  start-of-packet, qualified by int_valid.
- ptp_found  input  1  parser verdict; level, held until the next sop.
- ptp_infor  input  32  parser {msgid[3:0], cksum[11:0], seqid[15:0]}; valid while ptp_found=1.
- cfg_en  input  1  1 = pushes allowed.
- q_clear  input  1  synchronous flush pulse.
- q_rd  input  1  host pop strobe, one entry per cycle.
- q_rd_data  output  TS_W+32  head entry {ts, infor}; valid when q_empty=0.
- q_empty  output  1  queue empty.
- q_full  output  1  queue full.
- q_count  output  DEPTH_LOG2+1  number of stored entries.
- q_ovf_cnt  output  8  dropped-push counter, saturating.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - pointers=0, q_count=0, q_empty=1, q_full=0, q_ovf_cnt=0.
  - ts_pend=0, found_d1=0.
  - q_rd_data=0 (the empty head reads 0).
  - Reset mid-operation discards all entries immediately.
- Timestamp capture:
  - When int_valid&&int_sop, ts_pend <= rtc_time.
  - If a capture and a push occur on the same edge, the push uses the old ts_pend. The push belongs to the previous packet.
- Push detection:
  - found_d1 <= ptp_found every cycle.
  - push_req = ptp_found & ~found_d1 & cfg_en.
  - The entry is written on the edge where push_req=1, one clock after the parser asserts ptp_found.
  - The entry value is {ts_pend, ptp_infor}.
  - Exactly one push per packet: the parser drops ptp_found at each sop, so the next packet produces a new rising edge.
  - cfg_en=0 on the rise cycle loses that packet permanently. A later enable does not retroactively push it.
- Pop:
  - pop = q_rd & ~q_empty.
  - q_rd while empty is ignored: no pointer change, no error.
  - q_rd_data is first-word-fall-through: the head entry is visible combinationally from storage. The next entry appears the cycle after the pop edge.
- Storage and pointers:
  - Register array of 2^DEPTH_LOG2 entries, with wr_ptp and rd_ptr of DEPTH_LOG2 bits.
  - Pointers wrap modulo depth.
  - q_count is an explicit counter; q_empty = (q_count==0); q_full = (q_count==2^DEPTH_LOG2).
- Simultaneous push and pop (priority order):
  - q_clear=1 wins over everything:
    - pointers and count go to 0; q_ovf_cnt goes to 0;
    - a push or pop in the same cycle is discarded;
    - found_d1 still updates.
  - push & pop, not full: both occur; q_count unchanged.
  - push & pop while full: the pop frees a slot and the push is accepted. q_count stays at max; no overflow.
  - push & pop while empty: the pop is ignored and the push is accepted; q_count becomes 1.
  - push while full without pop: entry dropped and storage untouched; q_ovf_cnt increments, saturating at 255.
- Latency: a rising edge of ptp_found at cycle N gives q_empty=0 and the entry on q_rd_data at cycle N+1.
- Widths: q_count uses modulo-free arithmetic and never exceeds depth. Pointer arithmetic is DEPTH_LOG2 bits and wraps naturally.

Test Plan:
- Single event: rtc_time=64'h0000_0005_0000_1000 at sop, then ptp_found rises with infor=32'h1ABC_0007 -> next cycle q_empty=0, q_count=1, q_rd_data=96'h0000_0005_0000_1000_1ABC_0007. After q_rd -> q_empty=1.
- Fill and overflow: 18 PTP packets with no pops, DEPTH_LOG2=4 -> q_full=1 after the 16th, q_count=16, q_ovf_cnt=2. Popping 16 returns seqids 0..15 in order.
- Wrap: push 10 / pop 10 twice, then push 5 -> pointers wrap and the 5 entries read back in order; q_count=5.
- Simultaneous: with queue full, assert a push rise and q_rd in the same cycle -> q_count stays 16, q_ovf_cnt unchanged, new entry readable last. With queue empty, push+q_rd together -> q_count=1.
- Held level and cfg_en: ptp_found held high for 20 cycles -> exactly one push. A rise while cfg_en=0 -> no push, and raising cfg_en later does not push.
- q_clear and async reset: q_clear with 7 entries and a coincident push -> q_count=0, q_empty=1, q_ovf_cnt=0. rst_n pulsed low mid-burst -> all outputs return to reset values asynchronously, before the next clk edge.
